// File: rtl/pulse_blink_pkg.sv
// rtl/pulse_blink_pkg.sv - shared state encoding and ms-to-cycle helpers for pulse_blink
package pulse_blink_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned count_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_blink.sv
// rtl/pulse_blink.sv - queued fixed-length blink generator (FSM, shared timer, pending counter)
module pulse_blink
  import pulse_blink_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned ON_MS    = 100,
  parameter int unsigned OFF_MS   = 100,
  parameter int unsigned MAX_PEND = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              trig,
  output logic                              out,
  output logic                              busy,
  output logic [$clog2(MAX_PEND+1)-1:0]     pending
);

  localparam int unsigned ON_CYC  = ms_to_cycles(CLK_HZ, ON_MS);
  localparam int unsigned OFF_CYC = ms_to_cycles(CLK_HZ, OFF_MS);
  localparam int unsigned MAX_CYC = max_u(ON_CYC, OFF_CYC);
  localparam int unsigned CNT_W   = count_width(MAX_CYC);
  localparam int unsigned PEND_W  = $clog2(MAX_PEND + 1);

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  logic [1:0]        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [PEND_W-1:0] pend_nx, pend_sat_inc;
  logic              out_nx, busy_nx, cnt_last;

  assign cnt_last     = (cnt == '0);
  assign pend_sat_inc = (pending == PEND_MAX) ? pending : pending + PEND_W'(1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pending;
    out_nx   = out;
    case (state)
      ST_IDLE: begin
        if (trig) begin
          state_nx = ST_ON;
          cnt_nx   = ON_LOAD;
          out_nx   = 1'b1;
        end
      end
      ST_ON: begin
        if (trig) begin
          pend_nx = pend_sat_inc;
        end
        if (cnt_last) begin
          state_nx = ST_GAP;
          cnt_nx   = OFF_LOAD;
          out_nx   = 1'b0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_last) begin
          // A trig on the final gap edge is consumed directly by the next
          // blink, so the queue only shrinks when no new request arrives.
          if (trig || (pending != '0)) begin
            state_nx = ST_ON;
            cnt_nx   = ON_LOAD;
            out_nx   = 1'b1;
            if (!trig) begin
              pend_nx = pending - PEND_W'(1);
            end
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          cnt_nx = cnt - CNT_W'(1);
          if (trig) begin
            pend_nx = pend_sat_inc;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
        pend_nx  = '0;
        out_nx   = 1'b0;
      end
    endcase
    busy_nx = (state_nx != ST_IDLE) || (pend_nx != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pending <= '0;
      out     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pending <= pend_nx;
      out     <= out_nx;
      busy    <= busy_nx;
    end
  end

endmodule

// File: tb/tb_pulse_blink.sv
// tb/tb_pulse_blink.sv - scoreboard bench for pulse_blink against a timeline reference model
module tb_pulse_blink;

  localparam int ON   = 3;
  localparam int OFF  = 2;
  localparam int PER  = ON + OFF;
  localparam int MAXP = 2;

  typedef struct {
    logic out;
    logic busy;
    int   pend;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic       out, busy;
  logic [1:0] pending;

  int   n_checks = 0;
  int   n_pass = 0;
  bit   done = 1'b0;
  exp_t exp_q[$];

  // reference model: time since the current blink started plus a request count
  bit m_act = 1'b0;
  int m_k = 0;
  int m_pend = 0;

  pulse_blink #(
    .CLK_HZ(1000), .ON_MS(ON), .OFF_MS(OFF), .MAX_PEND(MAXP)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .out(out), .busy(busy), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input bit t, input bit r);
    if (r) begin
      m_act = 1'b0;
      m_pend = 0;
    end else if (!m_act) begin
      if (t) begin
        m_act = 1'b1;
        m_k = 0;
      end
    end else begin
      m_k = m_k + 1;
      if (m_k == PER) begin
        if (t || m_pend > 0) begin
          m_k = 0;
          if (!t) m_pend = m_pend - 1;
        end else begin
          m_act = 1'b0;
        end
      end else if (t && m_pend < MAXP) begin
        m_pend = m_pend + 1;
      end
    end
  endtask

  task automatic check_now(input string name, input logic o, input logic b, input int p,
                           input exp_t e);
    n_checks++;
    if (o === e.out && b === e.busy && p == e.pend) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t actual out=%b busy=%b pending=%0d required out=%b busy=%b pending=%0d",
               name, $time, o, b, p, e.out, e.busy, e.pend);
    end
  endtask

  // One clock of stimulus; r asserts reset (asynchronously, mid low phase).
  task automatic step(input bit t, input bit r);
    exp_t e;
    exp_t z;
    @(negedge clk);
    trig = t;
    if (r && !rst) begin
      rst = 1'b1;
      #1;
      z.out = 1'b0; z.busy = 1'b0; z.pend = 0;
      check_now("async_reset", out, busy, int'(pending), z);
    end else if (!r) begin
      rst = 1'b0;
    end
    model_edge(t && !r, r);
    e.out  = m_act && (m_k < ON);
    e.busy = m_act || (m_pend != 0);
    e.pend = m_pend;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input bit t);
    for (int i = 0; i < n; i++) step(t, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_now("cycle", out, busy, int'(pending), e);
      end
    end
  end

  initial begin : stim
    int dens;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    run(5, 1'b0);
    // single blink
    step(1'b1, 1'b0); run(10, 1'b0);
    // two requests, one queued
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); run(14, 1'b0);
    // burst of four during a blink saturates the queue
    step(1'b1, 1'b0); step(1'b0, 1'b0); run(4, 1'b1); run(20, 1'b0);
    // trig on the final gap edge with an empty queue
    step(1'b1, 1'b0); run(4, 1'b0); step(1'b1, 1'b0); run(12, 1'b0);
    // trig held three cycles from idle
    run(3, 1'b1); run(20, 1'b0);
    // reset mid-blink with a full queue, then trig right after release
    run(3, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b1);
    run(8, 1'b0);
    step(1'b0, 1'b1); step(1'b1, 1'b0); run(10, 1'b0);
    // randomized traffic with varying density and occasional resets
    for (int blk = 0; blk < 8; blk++) begin
      dens = $urandom_range(5, 70);
      for (int i = 0; i < 60; i++) begin
        step($urandom_range(0, 99) < dens, $urandom_range(0, 149) == 0);
      end
    end
    run(25, 1'b0);
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain actual %0d left required 0", exp_q.size());
    done = 1'b1;
  end

  initial begin : finisher
    fork
      wait (done);
      begin
        #100000;
        n_checks++;
        $display("FAIL timeout actual not done required done");
      end
    join_any
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
